fp_align_seq: RTL

- Alignment front-end for the team's floating-point adder; the parametrised, sequential successor to the 3-bit exponent-difference block.
- Computes the signed exponent difference and selects the larger exponent.
- Swaps operands so the larger-exponent mantissa is "big", then right-shifts the smaller mantissa one bit per cycle, keeping guard and sticky bits.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fp_align_pkg.sv | 23 ++
 rtl/exp_compare.sv | 18 +
 rtl/fp_align_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fp_align_pkg.sv
// Shared types and helpers for the floating-point alignment front-end.
// Holds the FSM state encoding, the aligned-width rule and the shift-count helper.
package fp_align_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Aligned mantissa carries guard and sticky below the mantissa bits.
    function automatic int sh_width(input int man_w);
        return man_w + 2;
    endfunction

    // Magnitude of a signed difference, clamped to limit.
    function automatic int abs_sat(input int diff, input int limit);
        int mag;
        mag = (diff < 0) ? -diff : diff;
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/exp_compare.sv
// Combinational exponent comparator: signed difference, larger exponent, swap flag.
// Ports: exp_a, exp_b in; diff (EXP_W+1 two's complement), exp_max, swap out.
module exp_compare #(
    parameter int EXP_W = 3
) (
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    output logic [EXP_W:0]   diff,
    output logic [EXP_W-1:0] exp_max,
    output logic             swap
);

    // One extra bit so the sign of a - b is never lost.
    assign diff    = {1'b0, exp_a} - {1'b0, exp_b};
    assign swap    = diff[EXP_W];
    assign exp_max = swap ? exp_b : exp_a;

endmodule

// File: rtl/fp_align_seq.sv
// Sequential alignment stage for the FP adder: captures an operand pair, orders it
// by exponent and shifts the smaller mantissa right one bit per cycle with guard/sticky.
// Ports: clk, rst (async high); in_valid/in_ready upstream; out_valid/out_ready downstream;
// exp_a/exp_b/man_a/man_b operands; exp_diff, exp_out, swap, man_big, man_small results.
module fp_align_seq
    import fp_align_pkg::*;
#(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    localparam int SH_W = sh_width(MAN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W:0]   exp_diff,
    output logic [EXP_W-1:0] exp_out,
    output logic             swap,
    output logic [MAN_W-1:0] man_big,
    output logic [SH_W-1:0]  man_small
);

    localparam int CNT_W = $clog2(SH_W + 1);

    logic [EXP_W:0]   cmp_diff;
    logic [EXP_W-1:0] cmp_max;
    logic             cmp_swap;
    logic [CNT_W-1:0] cnt_init;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [EXP_W:0]   diff_q, diff_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             swap_q, swap_d;
    logic [MAN_W-1:0] big_q, big_d;
    logic             ov_q, ov_d;

    exp_compare #(
        .EXP_W (EXP_W)
    ) u_cmp (
        .exp_a   (exp_a),
        .exp_b   (exp_b),
        .diff    (cmp_diff),
        .exp_max (cmp_max),
        .swap    (cmp_swap)
    );

    // Shifts past SH_W only keep feeding zeros into sticky, so clamp there.
    assign cnt_init = CNT_W'(abs_sat(int'($signed(cmp_diff)), SH_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        diff_d  = diff_q;
        exp_d   = exp_q;
        swap_d  = swap_q;
        big_d   = big_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    diff_d  = cmp_diff;
                    exp_d   = cmp_max;
                    swap_d  = cmp_swap;
                    big_d   = cmp_swap ? man_b : man_a;
                    sh_d    = {(cmp_swap ? man_a : man_b), 2'b00};
                    cnt_d   = cnt_init;
                    state_d = (cnt_init == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Bit 0 is sticky: it ORs in whatever falls off the guard position.
                sh_d  = {1'b0, sh_q[SH_W-1:2], sh_q[1] | sh_q[0]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle only raises out_valid; handshake from then on.
                if (!ov_q) begin
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ov_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            diff_q  <= '0;
            exp_q   <= '0;
            swap_q  <= 1'b0;
            big_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            diff_q  <= diff_d;
            exp_q   <= exp_d;
            swap_q  <= swap_d;
            big_q   <= big_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign exp_diff  = diff_q;
    assign exp_out   = exp_q;
    assign swap      = swap_q;
    assign man_big   = big_q;
    assign man_small = sh_q;

endmodule
